factorial_dispatcher: RTL
=========================

# factorial_dispatcher

Request-side front end for the factorial core. It accepts argument requests over a valid/ready handshake and buffers them in a small FIFO. It issues each request to the core only while the core is not busy, captures the matching result, and presents argument plus result downstream over a valid/ready handshake. It also flags core timeouts and unsolicited core outputs.

## Interface
Parameters:
- IN_DATA_WD, 3, factorial argument width
- OUT_DATA_WD, 16, factorial result width
- REQ_DEPTH, 4, request FIFO depth (power of two, >=2)
- TIMEOUT_CYCLES, 64, maximum cycles to wait for core out_valid after issue

Ports:
- clk  input  1  single clock, all logic on rising edge
- resetn  input  1  reset is synchronous and active-low
- req_valid  input  1  upstream request valid
- req_ready  output  1  FIFO can accept (= not full)
- req_data  input  IN_DATA_WD  requested argument
- fact_in_data  output  IN_DATA_WD  argument to core
- fact_in_valid  output  1  one-cycle issue strobe to core
- fact_out_data  input  OUT_DATA_WD  core result
- fact_out_valid  input  1  core result strobe
- fact_out_busy  input  1  core computing
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream accepts response
- rsp_arg  output  IN_DATA_WD  argument of this response
- rsp_data  output  OUT_DATA_WD  factorial result
- err_timeout  output  1  sticky: a request timed out
- err_spurious  output  1  sticky: fact_out_valid outside WAIT

## Operation
- Request push on req_valid && req_ready. req_ready = !full (combinational from count). Pop only in ISSUE.
- FSM states IDLE, ISSUE, WAIT, HOLD:
  - IDLE: FIFO non-empty && !fact_out_busy -> ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): fact_in_valid=1, fact_in_data=FIFO head. Pop head, latch it as pending arg, clear timer -> WAIT.
  - WAIT: timer increments each cycle. fact_out_valid=1 -> capture rsp_data=fact_out_data, rsp_arg=pending arg, rsp_valid=1 -> HOLD. Timer reaches TIMEOUT_CYCLES-1 without out_valid -> set err_timeout, drop request -> IDLE.
  - HOLD: rsp_valid, rsp_arg, rsp_data held stable until rsp_valid && rsp_ready -> rsp_valid=0 -> IDLE.
- If fact_out_valid and the timeout terminal count occur in the same cycle, the result wins: go to HOLD, err_timeout unchanged.
- fact_out_valid in IDLE, ISSUE or HOLD: ignored, err_spurious set. HOLD registers are not overwritten.
- Error flags clear only on reset.
- fact_in_valid outside ISSUE is 0. fact_in_data drives the FIFO head when fact_in_valid=0 and is don't-care then.
- Full FIFO with push attempt: req_ready=0, no push. Push and pop in the same cycle are allowed when not full; count is unchanged.
- Timer width: $clog2(TIMEOUT_CYCLES)+1. No wrap is possible because WAIT exits at terminal count.

## Timing
- Reset (resetn low at a rising edge): state=IDLE, FIFO empty, count=0. Outputs: fact_in_valid=0, fact_in_data=0, rsp_valid=0, rsp_arg=0, rsp_data=0, err_timeout=0, err_spurious=0. req_ready=1 after reset; req_valid is ignored while resetn=0.
- Reset mid-operation discards FIFO contents, the pending request and any held response. A late core out_valid after reset flags err_spurious.
- Issue latency, idle core, empty FIFO:
  - request accepted at edge E0;
  - FSM enters ISSUE at E1;
  - fact_in_valid high during cycle E1–E2.
- Result latency: core out_valid sampled at edge Ek gives rsp_valid=1 from Ek.
- Back-to-back: after the rsp handshake at edge Eh, IDLE at Eh and the next ISSUE at Eh+1 at the earliest. Throughput is at most one request in flight.
- fact_out_busy is sampled only in IDLE.

## Structure
- Package factorial_pkg:
  - IN_DATA_WD and OUT_DATA_WD defaults, shared with the core and its interface;
  - state enum dispatch_state_t {IDLE, ISSUE, WAIT, HOLD};
  - typedef arg_t and result_t.
- Sub-module factorial_req_fifo: synchronous FIFO, REQ_DEPTH x IN_DATA_WD.
  - Ports: clk, resetn, push, push_data, pop, head, full, empty, count.
  - First-word-fall-through: head is valid whenever !empty.
- FSM, timer, response registers and error flags live in factorial_dispatcher.

## Test plan
- Single request: push arg 5, core returns 120 four cycles after issue, rsp_ready=1 -> one fact_in_valid pulse with data 5; rsp_valid with rsp_arg=5, rsp_data=120; FIFO empty.
- Burst with backpressure: push 0,3,7,4,6 back-to-back -> req_ready low after the fourth push until the first pop. Issues occur in order, each only when busy=0. Responses are (0,1),(3,6),(7,5040),(4,24), then (6,720) after the fifth push completes. With rsp_ready held low 10 cycles, rsp fields stay stable.
- Timeout: push 2, core never asserts out_valid -> err_timeout=1 exactly TIMEOUT_CYCLES cycles after issue; no rsp_valid; the next request 3 still yields (3,6).
- Spurious output: fact_out_valid pulse with data 0xBEEF while IDLE, and again while HOLD holding (4,24) -> err_spurious=1; held response remains (4,24).
- Busy gating: core busy=1 while FIFO holds arg 1 -> no fact_in_valid until the cycle after busy drops; then (1,1).
- Reset mid-WAIT: after issuing arg 6 with 2 more entries queued, resetn low 1 cycle -> all outputs 0, req_ready=1, FIFO empty. A later out_valid sets err_spurious.

Source files
------------

// File: rtl/factorial_pkg.sv
// Shared types and default widths for the factorial core and its dispatcher.
package factorial_pkg;

   localparam int DEF_IN_DATA_WD  = 3;
   localparam int DEF_OUT_DATA_WD = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } dispatch_state_t;

   typedef logic [DEF_IN_DATA_WD-1:0]  arg_t;
   typedef logic [DEF_OUT_DATA_WD-1:0] result_t;

endpackage

// File: rtl/factorial_dispatcher_if.sv
// Request, core and response signals of the factorial dispatcher.
interface factorial_dispatcher_if
   import factorial_pkg::*;
#(
   parameter int IN_DATA_WD  = DEF_IN_DATA_WD,
   parameter int OUT_DATA_WD = DEF_OUT_DATA_WD
);

   logic                   req_valid;
   logic                   req_ready;
   logic [IN_DATA_WD-1:0]  req_data;
   logic [IN_DATA_WD-1:0]  fact_in_data;
   logic                   fact_in_valid;
   logic [OUT_DATA_WD-1:0] fact_out_data;
   logic                   fact_out_valid;
   logic                   fact_out_busy;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IN_DATA_WD-1:0]  rsp_arg;
   logic [OUT_DATA_WD-1:0] rsp_data;
   logic                   err_timeout;
   logic                   err_spurious;

   modport slave (
      input  req_valid,
      input  req_data,
      input  fact_out_data,
      input  fact_out_valid,
      input  fact_out_busy,
      input  rsp_ready,
      output req_ready,
      output fact_in_data,
      output fact_in_valid,
      output rsp_valid,
      output rsp_arg,
      output rsp_data,
      output err_timeout,
      output err_spurious
   );

   modport master (
      output req_valid,
      output req_data,
      output fact_out_data,
      output fact_out_valid,
      output fact_out_busy,
      output rsp_ready,
      input  req_ready,
      input  fact_in_data,
      input  fact_in_valid,
      input  rsp_valid,
      input  rsp_arg,
      input  rsp_data,
      input  err_timeout,
      input  err_spurious
   );

endinterface

// File: rtl/factorial_req_fifo.sv
// First-word-fall-through request FIFO; storage clears on reset.
module factorial_req_fifo
   import factorial_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WD    = DEF_IN_DATA_WD
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WD-1:0]            push_data,
   input  logic                     pop,
   output logic [WD-1:0]            head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WD-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/factorial_dispatcher.sv
// Queues factorial requests, issues one at a time to the core and
// holds each result for downstream; flags core timeouts and stray results.
module factorial_dispatcher
   import factorial_pkg::*;
#(
   parameter int IN_DATA_WD     = DEF_IN_DATA_WD,
   parameter int OUT_DATA_WD    = DEF_OUT_DATA_WD,
   parameter int REQ_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                  clk,
   input logic                  resetn,
   factorial_dispatcher_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int CW = $clog2(REQ_DEPTH) + 1;
   localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES - 1);

   dispatch_state_t        state;
   logic [TW-1:0]          timer;
   logic [IN_DATA_WD-1:0]  pend_arg;
   logic [IN_DATA_WD-1:0]  head;
   logic [CW-1:0]          count;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   issue;
   logic                   rsp_valid;
   logic [IN_DATA_WD-1:0]  rsp_arg;
   logic [OUT_DATA_WD-1:0] rsp_data;
   logic                   err_timeout;
   logic                   err_spurious;

   assign push = bus.req_valid && !full;
   assign pop  = (state == ISSUE) && !empty;

   assign bus.req_ready     = !full;
   assign bus.fact_in_data  = head;
   assign bus.fact_in_valid = issue;
   assign bus.rsp_valid     = rsp_valid;
   assign bus.rsp_arg       = rsp_arg;
   assign bus.rsp_data      = rsp_data;
   assign bus.err_timeout   = err_timeout;
   assign bus.err_spurious  = err_spurious;

   factorial_req_fifo #(
      .DEPTH (REQ_DEPTH),
      .WD    (IN_DATA_WD)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data (bus.req_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         timer        <= '0;
         pend_arg     <= '0;
         issue        <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_arg      <= '0;
         rsp_data     <= '0;
         err_timeout  <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         issue <= 1'b0;
         if (bus.fact_out_valid && state != WAIT) begin
            err_spurious <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (count != '0 && !bus.fact_out_busy) begin
                  state <= ISSUE;
                  issue <= 1'b1;
               end
            end
            ISSUE: begin
               pend_arg <= head;
               timer    <= '0;
               state    <= WAIT;
            end
            // A result arriving on the terminal count still wins
            WAIT: begin
               if (bus.fact_out_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_arg   <= pend_arg;
                  rsp_data  <= bus.fact_out_data;
                  state     <= HOLD;
               end else if (timer == TERM) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            HOLD: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
